// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: byte width, FSM encodings
// and the small types used by the top level and its FIFO.
package uart_tx_scheduler_pkg;

    localparam int UART_DATA_W = 8;

    typedef logic [1:0]             state_t;
    typedef logic [UART_DATA_W-1:0] uart_byte_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_LOAD      = 2'd1;
    localparam state_t ST_WAIT_BUSY = 2'd2;
    localparam state_t ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/uart_tx_scheduler_sync_fifo.sv
// Single-clock FIFO with registered storage, free-running power-of-two pointers
// and a separately tracked occupancy count.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          wr_en, rd_en;

    assign full  = (level_q == FULL_LEVEL);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign dout  = mem_q[rd_ptr_q];

    // A write into a full FIFO is still legal when the head leaves on the same edge.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && wr_en) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Queues CPU bytes and hands them to the UART one at a time, issuing a single
// write pulse only when the transmitter reports empty.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int AW           = 4,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   cpu_load,
    input  logic [UART_DATA_W-1:0] cpu_din,
    output logic                   cpu_te,
    input  logic                   uart_te,
    output logic                   uart_wr,
    output logic [UART_DATA_W-1:0] uart_din,
    output logic [AW:0]            fifo_level,
    output logic                   overflow
);

    localparam int          TW         = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          uart_wr_q, uart_wr_d;
    uart_byte_t    uart_din_q, uart_din_d;
    logic          overflow_q, overflow_d;

    uart_byte_t    fifo_dout;
    logic          fifo_full, fifo_empty;
    logic          fifo_pop, push_ok;

    // The head leaves the FIFO during the single LOAD cycle, which is also the wr pulse cycle.
    assign fifo_pop = (state_q == ST_LOAD) && !fifo_empty;
    assign push_ok  = cpu_load && (!fifo_full || fifo_pop);

    sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (UART_DATA_W)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (cpu_load),
        .pop    (fifo_pop),
        .din    (cpu_din),
        .dout   (fifo_dout),
        .level  (fifo_level),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign cpu_te   = !fifo_full;
    assign uart_wr  = uart_wr_q;
    assign uart_din = uart_din_q;
    assign overflow = overflow_q;

    // The wr pulse and its byte are registered on the IDLE->LOAD decision so they
    // are high for exactly the LOAD cycle; WAIT_BUSY times out if TE never drops.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        uart_wr_d  = 1'b0;
        uart_din_d = uart_din_q;
        overflow_d = overflow_q || (cpu_load && !push_ok);
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && uart_te) begin
                    state_d    = ST_LOAD;
                    uart_wr_d  = 1'b1;
                    uart_din_d = fifo_dout;
                end
            end
            ST_LOAD: begin
                state_d = ST_WAIT_BUSY;
                timer_d = '0;
            end
            ST_WAIT_BUSY: begin
                if (!uart_te) begin
                    state_d = ST_WAIT_DONE;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (uart_te) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            uart_wr_q  <= 1'b0;
            uart_din_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            uart_wr_q  <= uart_wr_d;
            uart_din_q <= uart_din_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed and randomized bench for uart_tx_scheduler with a queue-based
// model of the FIFO contents, occupancy and overflow flag.
module tb_uart_tx_scheduler;

    logic       clk;
    logic       resetn;
    logic       cpu_load;
    logic [7:0] cpu_din;
    logic       cpu_te;
    logic       uart_te;
    logic       uart_wr;
    logic [7:0] uart_din;
    logic [4:0] fifo_level;
    logic       overflow;

    int         tests    = 0;
    int         failures = 0;
    logic [7:0] rx_q[$];

    uart_tx_scheduler dut (
        .clk        (clk),
        .resetn     (resetn),
        .cpu_load   (cpu_load),
        .cpu_din    (cpu_din),
        .cpu_te     (cpu_te),
        .uart_te    (uart_te),
        .uart_wr    (uart_wr),
        .uart_din   (uart_din),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic load, input logic [7:0] din, input logic te);
        cpu_load = load;
        cpu_din  = din;
        uart_te  = te;
        step();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    // Simple UART: after each write TE stays high one cycle, then low three cycles
    // (or never drops when ignore is set). Collects issued bytes into rx_q.
    task automatic drainUart(input int count, input int budget, input bit ignore);
        int delay = 0;
        int low_left = 0;
        int used = 0;
        rx_q.delete();
        cpu_load = 1'b0;
        while (rx_q.size() < count && used < budget) begin
            if (delay > 0) begin
                uart_te = 1'b1;
                delay--;
            end else if (low_left > 0) begin
                uart_te = 1'b0;
                low_left--;
            end else begin
                uart_te = 1'b1;
            end
            step();
            used++;
            if (uart_wr) begin
                rx_q.push_back(uart_din);
                if (!ignore) begin
                    delay    = 1;
                    low_left = 3;
                end
            end
        end
        checkOutput("drain_count", rx_q.size(), count);
    endtask

    initial begin
        int         wr_count;
        int         t_first, t_second;
        logic [7:0] b_first, b_second;
        logic [7:0] model[$];
        logic [7:0] exp_q[$];
        bit         ov_model;
        int         delay, low;
        bit         ld, te, pop_now, acc;
        logic [7:0] d;

        resetn   = 1'b0;
        cpu_load = 1'b0;
        cpu_din  = 8'h00;
        uart_te  = 1'b1;

        // Test 1: reset values, single byte latency, no repeat pulse
        doReset();
        checkOutput("rst_uart_wr", uart_wr, 0);
        checkOutput("rst_uart_din", uart_din, 8'h00);
        checkOutput("rst_level", fifo_level, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_cpu_te", cpu_te, 1);
        applyStimulus(1'b1, 8'h41, 1'b1);
        checkOutput("t1_wr_n1", uart_wr, 0);
        checkOutput("t1_level_n1", fifo_level, 1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t1_wr_n2", uart_wr, 1);
        checkOutput("t1_din_n2", uart_din, 8'h41);
        wr_count = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            wr_count += int'(uart_wr);
        end
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            wr_count += int'(uart_wr);
        end
        checkOutput("t1_no_second_wr", wr_count, 0);
        checkOutput("t1_level_empty", fifo_level, 0);
        checkOutput("t1_din_hold", uart_din, 8'h41);
        applyStimulus(1'b1, 8'h42, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t1_idle_again_wr", uart_wr, 1);
        checkOutput("t1_idle_again_din", uart_din, 8'h42);

        // Test 2: burst to full, overflow drop, in-order drain
        doReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0);
        end
        checkOutput("t2_level_full", fifo_level, 16);
        checkOutput("t2_cpu_te_full", cpu_te, 0);
        checkOutput("t2_ovf_before", overflow, 0);
        applyStimulus(1'b1, 8'hFF, 1'b0);
        checkOutput("t2_ovf_set", overflow, 1);
        checkOutput("t2_level_stays", fifo_level, 16);
        drainUart(16, 800, 1'b0);
        for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
            checkOutput("t2_order", rx_q[i], 8'(i));
        end
        wr_count = 0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            wr_count += int'(uart_wr);
        end
        checkOutput("t2_no_ff", wr_count, 0);
        checkOutput("t2_ovf_sticky", overflow, 1);
        checkOutput("t2_cpu_te_empty", cpu_te, 1);

        // Test 3: push into a full FIFO during the LOAD cycle
        doReset();
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(8'h20 + i), 1'b0);
            exp_q.push_back(8'(8'h20 + i));
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t3_load_wr", uart_wr, 1);
        checkOutput("t3_load_din", uart_din, 8'h20);
        void'(exp_q.pop_front());
        applyStimulus(1'b1, 8'hA5, 1'b0);
        exp_q.push_back(8'hA5);
        checkOutput("t3_level", fifo_level, 16);
        checkOutput("t3_ovf", overflow, 0);
        checkOutput("t3_wr_low", uart_wr, 0);
        drainUart(16, 800, 1'b0);
        for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
            checkOutput("t3_order", rx_q[i], exp_q[i]);
        end

        // Test 4: UART never drops TE; busy timeout releases the next byte
        doReset();
        wr_count = 0;
        t_first = -1;
        t_second = -1;
        b_first = 8'h00;
        b_second = 8'h00;
        for (int c = 0; c < 40; c++) begin
            applyStimulus(c < 2, (c == 0) ? 8'h55 : 8'h66, 1'b1);
            if (uart_wr) begin
                if (wr_count == 0) begin
                    t_first = c;
                    b_first = uart_din;
                end else if (wr_count == 1) begin
                    t_second = c;
                    b_second = uart_din;
                end
                wr_count++;
            end
        end
        checkOutput("t4_wr_count", wr_count, 2);
        checkOutput("t4_first_time", t_first, 1);
        checkOutput("t4_gap", t_second - t_first, 10);
        checkOutput("t4_first_byte", b_first, 8'h55);
        checkOutput("t4_second_byte", b_second, 8'h66);

        // Test 5: reset during WAIT_DONE with bytes queued
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 8'(8'h70 + i), 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t5_load_wr", uart_wr, 1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t5_level_queued", fifo_level, 5);
        resetn = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        resetn = 1'b1;
        checkOutput("t5_level_rst", fifo_level, 0);
        checkOutput("t5_wr_rst", uart_wr, 0);
        checkOutput("t5_ovf_rst", overflow, 0);
        checkOutput("t5_cpu_te_rst", cpu_te, 1);
        wr_count = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            wr_count += int'(uart_wr);
        end
        checkOutput("t5_no_wr", wr_count, 0);
        applyStimulus(1'b1, 8'h99, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t5_new_wr", uart_wr, 1);
        checkOutput("t5_new_din", uart_din, 8'h99);

        // Test 6: random push / TE stress against the queue model
        doReset();
        model.delete();
        ov_model = 1'b0;
        delay = 0;
        low = 0;
        for (int c = 0; c < 13000; c++) begin
            if (c >= 10000 && model.size() == 0) break;
            ld = (c < 10000) && ($urandom_range(0, 99) < ((c < 5000) ? 10 : 25));
            d  = 8'($urandom);
            if (delay > 0) begin
                te = 1'b1;
                delay--;
            end else if (low > 0) begin
                te = 1'b0;
                low--;
            end else begin
                te = ($urandom_range(0, 19) != 0);
            end
            pop_now = uart_wr;
            acc = ld && (model.size() < 16 || pop_now);
            applyStimulus(ld, d, te);
            if (pop_now && model.size() != 0) void'(model.pop_front());
            if (acc) model.push_back(d);
            else if (ld) ov_model = 1'b1;
            checkOutput("s_level", fifo_level, model.size());
            checkOutput("s_overflow", overflow, ov_model);
            checkOutput("s_cpu_te", cpu_te, model.size() != 16);
            if (uart_wr) begin
                checkOutput("s_consecutive_wr", pop_now, 0);
                checkOutput("s_te_at_decision", te, 1);
                checkOutput("s_wr_nonempty", model.size() != 0, 1);
                if (model.size() != 0) checkOutput("s_data", uart_din, model[0]);
                if ($urandom_range(0, 9) != 0) begin
                    delay = $urandom_range(0, 2);
                    low   = $urandom_range(1, 6);
                end
            end
        end
        checkOutput("s_drained", model.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
